// File: rtl/integer_systolic_pe.sv
// Signed integer MAC processing element for a systolic array.
// A/B are forwarded east/south; finished dot products drain down the C chain.
module integer_systolic_pe #(
    parameter int WIDTH    = 8,
    parameter int ACC      = 32,
    parameter bit SATURATE = 1'b1
) (
    input  logic                    clock,
    input  logic                    resetN,
    input  logic signed [WIDTH-1:0] aIn,
    input  logic                    aValidIn,
    input  logic                    lastIn,
    input  logic signed [WIDTH-1:0] bIn,
    input  logic                    bValidIn,
    output logic signed [WIDTH-1:0] aOut,
    output logic                    aValidOut,
    output logic                    lastOut,
    output logic signed [WIDTH-1:0] bOut,
    output logic                    bValidOut,
    input  logic signed [ACC-1:0]   cIn,
    input  logic                    cSatIn,
    input  logic                    cValidIn,
    output logic                    cReadyOut,
    output logic signed [ACC-1:0]   cOut,
    output logic                    cSatOut,
    output logic                    cValidOut,
    input  logic                    cReadyIn,
    output logic                    errOut
);
    localparam int PW = 2 * WIDTH;

    logic [WIDTH-1:0] a_q, b_q;
    logic             av_q, bv_q, last_q;
    logic [ACC-1:0]   acc_q, acc_d;
    logic             sat_q, sat_d;
    logic [ACC-1:0]   res_q, res_d;
    logic             rsat_q, rsat_d;
    logic             pend_q, pend_d;
    logic [ACC-1:0]   cout_q, cout_d;
    logic             csat_q, csat_d;
    logic             cvalid_q, cvalid_d;
    logic             err_q, err_d;

    logic signed [PW-1:0] prod;
    logic [ACC:0]         sum_w;
    logic [ACC-1:0]       sum_n;
    logic                 ovf, sat_n;
    logic                 mac, lst, free;

    assign prod  = aIn * bIn;
    assign sum_w = {acc_q[ACC-1], acc_q}
                 + {{(ACC+1-PW){prod[PW-1]}}, prod};
    // One guard bit: the top two bits disagree exactly on overflow
    assign ovf   = sum_w[ACC] ^ sum_w[ACC-1];
    assign sat_n = sat_q | ovf;

    always_comb begin
        sum_n = sum_w[ACC-1:0];
        if (SATURATE && ovf) begin
            if (sum_w[ACC]) sum_n = {1'b1, {(ACC-1){1'b0}}};
            else            sum_n = {1'b0, {(ACC-1){1'b1}}};
        end
    end

    assign mac       = aValidIn & bValidIn;
    assign lst       = mac & lastIn;
    assign free      = ~cvalid_q | cReadyIn;
    assign cReadyOut = free & ~pend_q;

    always_comb begin
        acc_d    = acc_q;
        sat_d    = sat_q;
        res_d    = res_q;
        rsat_d   = rsat_q;
        pend_d   = pend_q;
        cout_d   = cout_q;
        csat_d   = csat_q;
        cvalid_d = cvalid_q;
        err_d    = err_q;
        if (free) begin
            if (pend_q) begin
                cout_d   = res_q;
                csat_d   = rsat_q;
                cvalid_d = 1'b1;
                pend_d   = 1'b0;
            end else if (cValidIn) begin
                cout_d   = cIn;
                csat_d   = cSatIn;
                cvalid_d = 1'b1;
            end else begin
                cvalid_d = 1'b0;
            end
        end
        // pend_d already reflects a same-edge drain, so back-to-back loads succeed
        if (lst) begin
            acc_d = '0;
            sat_d = 1'b0;
            if (!pend_d) begin
                res_d  = sum_n;
                rsat_d = sat_n;
                pend_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end else if (mac) begin
            acc_d = sum_n;
            sat_d = sat_n;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            a_q      <= '0;
            b_q      <= '0;
            av_q     <= 1'b0;
            bv_q     <= 1'b0;
            last_q   <= 1'b0;
            acc_q    <= '0;
            sat_q    <= 1'b0;
            res_q    <= '0;
            rsat_q   <= 1'b0;
            pend_q   <= 1'b0;
            cout_q   <= '0;
            csat_q   <= 1'b0;
            cvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            a_q      <= aIn;
            b_q      <= bIn;
            av_q     <= aValidIn;
            bv_q     <= bValidIn;
            last_q   <= lastIn;
            acc_q    <= acc_d;
            sat_q    <= sat_d;
            res_q    <= res_d;
            rsat_q   <= rsat_d;
            pend_q   <= pend_d;
            cout_q   <= cout_d;
            csat_q   <= csat_d;
            cvalid_q <= cvalid_d;
            err_q    <= err_d;
        end
    end

    assign aOut      = a_q;
    assign aValidOut = av_q;
    assign lastOut   = last_q;
    assign bOut      = b_q;
    assign bValidOut = bv_q;
    assign cOut      = cout_q;
    assign cSatOut   = csat_q;
    assign cValidOut = cvalid_q;
    assign errOut    = err_q;
endmodule

// File: tb/tb_integer_systolic_pe.sv
// Bench for integer_systolic_pe: per-cycle model compare on the default
// instance plus directed literal checks, including two ACC=16 instances.
module tb_integer_systolic_pe;
    logic clock = 1'b0;
    logic resetN = 1'b0;
    always #5 clock = ~clock;

    logic signed [7:0]  aIn = '0, bIn = '0;
    logic               aValidIn = 0, bValidIn = 0, lastIn = 0;
    logic signed [31:0] cIn = '0;
    logic               cSatIn = 0, cValidIn = 0, cReadyIn = 1;
    logic signed [7:0]  aOut, bOut;
    logic               aValidOut, bValidOut, lastOut;
    logic               cReadyOut, cSatOut, cValidOut, errOut;
    logic signed [31:0] cOut;

    integer_systolic_pe #(.WIDTH(8), .ACC(32), .SATURATE(1'b1)) dut (
        .clock(clock), .resetN(resetN),
        .aIn(aIn), .aValidIn(aValidIn), .lastIn(lastIn),
        .bIn(bIn), .bValidIn(bValidIn),
        .aOut(aOut), .aValidOut(aValidOut), .lastOut(lastOut),
        .bOut(bOut), .bValidOut(bValidOut),
        .cIn(cIn), .cSatIn(cSatIn), .cValidIn(cValidIn),
        .cReadyOut(cReadyOut),
        .cOut(cOut), .cSatOut(cSatOut), .cValidOut(cValidOut),
        .cReadyIn(cReadyIn), .errOut(errOut)
    );

    logic signed [7:0]  sA = '0, sB = '0;
    logic               sV = 0, sL = 0;
    logic signed [15:0] sCin = '0;
    logic signed [7:0]  s1aO, s1bO, s0aO, s0bO;
    logic               s1av, s1bv, s1lo, s1rdy, s1cs, s1cv, s1err;
    logic               s0av, s0bv, s0lo, s0rdy, s0cs, s0cv, s0err;
    logic signed [15:0] s1c, s0c;

    integer_systolic_pe #(.WIDTH(8), .ACC(16), .SATURATE(1'b1)) dut_s1 (
        .clock(clock), .resetN(resetN),
        .aIn(sA), .aValidIn(sV), .lastIn(sL),
        .bIn(sB), .bValidIn(sV),
        .aOut(s1aO), .aValidOut(s1av), .lastOut(s1lo),
        .bOut(s1bO), .bValidOut(s1bv),
        .cIn(sCin), .cSatIn(1'b0), .cValidIn(1'b0),
        .cReadyOut(s1rdy),
        .cOut(s1c), .cSatOut(s1cs), .cValidOut(s1cv),
        .cReadyIn(1'b1), .errOut(s1err)
    );

    integer_systolic_pe #(.WIDTH(8), .ACC(16), .SATURATE(1'b0)) dut_s0 (
        .clock(clock), .resetN(resetN),
        .aIn(sA), .aValidIn(sV), .lastIn(sL),
        .bIn(sB), .bValidIn(sV),
        .aOut(s0aO), .aValidOut(s0av), .lastOut(s0lo),
        .bOut(s0bO), .bValidOut(s0bv),
        .cIn(sCin), .cSatIn(1'b0), .cValidIn(1'b0),
        .cReadyOut(s0rdy),
        .cOut(s0c), .cSatOut(s0cs), .cValidOut(s0cv),
        .cReadyIn(1'b1), .errOut(s0err)
    );

    int nchk = 0;
    int nerr = 0;
    bit chk_on = 0;

    task automatic check(input string nm,
                         input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Model: plain integer arithmetic with clamping, a one-deep
    // pending result and a one-entry output slot.
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;
    longint m_acc = 0, m_res = 0, m_c = 0, sum;
    bit     m_sat = 0, m_rsat = 0, m_pend = 0, m_cv = 0, m_cs = 0;
    bit     m_err = 0, s;
    longint m_a = 0, m_b = 0;
    bit     m_av = 0, m_bv = 0, m_l = 0;

    always @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            m_acc = 0; m_res = 0; m_c = 0;
            m_sat = 0; m_rsat = 0; m_pend = 0;
            m_cv = 0; m_cs = 0; m_err = 0;
            m_a = 0; m_b = 0; m_av = 0; m_bv = 0; m_l = 0;
        end else begin
            if (!m_cv || cReadyIn) begin
                if (m_pend) begin
                    m_c = m_res; m_cs = m_rsat;
                    m_cv = 1; m_pend = 0;
                end else if (cValidIn) begin
                    m_c = longint'(cIn); m_cs = cSatIn; m_cv = 1;
                end else begin
                    m_cv = 0;
                end
            end
            if (aValidIn && bValidIn) begin
                sum = m_acc + longint'(aIn) * longint'(bIn);
                s = m_sat;
                if (sum > MAXV) begin sum = MAXV; s = 1; end
                if (sum < MINV) begin sum = MINV; s = 1; end
                if (lastIn) begin
                    if (!m_pend) begin
                        m_res = sum; m_rsat = s; m_pend = 1;
                    end else begin
                        m_err = 1;
                    end
                    m_acc = 0; m_sat = 0;
                end else begin
                    m_acc = sum; m_sat = s;
                end
            end
            m_a = longint'(aIn); m_b = longint'(bIn);
            m_av = aValidIn; m_bv = bValidIn; m_l = lastIn;
        end
    end

    always @(negedge clock) begin
        if (chk_on) begin
            check("m_aOut", aOut, m_a);
            check("m_aValid", aValidOut, m_av);
            check("m_last", lastOut, m_l);
            check("m_bOut", bOut, m_b);
            check("m_bValid", bValidOut, m_bv);
            check("m_cValid", cValidOut, m_cv);
            if (m_cv) begin
                check("m_cOut", cOut, m_c);
                check("m_cSat", cSatOut, m_cs);
            end
            check("m_cReady", cReadyOut, (!m_cv || cReadyIn) && !m_pend);
            check("m_err", errOut, m_err);
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic drv(input int a, input int b,
                       input bit av, input bit bv, input bit l);
        aIn = 8'(a); bIn = 8'(b);
        aValidIn = av; bValidIn = bv; lastIn = l;
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1 resetN = 1'b1;
        chk_on = 1;
        check("rst_cValid", cValidOut, 0);
        check("rst_err", errOut, 0);
        check("rst_aValid", aValidOut, 0);
        check("rst_cReady", cReadyOut, 1);

        // (3,-4),(5,2,last) = -2
        drv(3, -4, 1, 1, 0); cyc();
        drv(5, 2, 1, 1, 1);  cyc();
        check("dot_lat0", cValidOut, 0);
        drv(0, 0, 0, 0, 0);  cyc();
        check("dot_valid", cValidOut, 1);
        check("dot_val", cOut, -2);
        check("dot_sat", cSatOut, 0);
        drv(1, 1, 1, 1, 1); cyc();
        drv(0, 0, 0, 0, 0); cyc();
        check("dot_fresh", cOut, 1);

        // A forwarded while B invalid, no MAC
        drv(-7, 9, 1, 0, 0); cyc();
        check("fwd_a", aOut, -7);
        check("fwd_av", aValidOut, 1);
        check("fwd_bv", bValidOut, 0);
        drv(1, 1, 1, 1, 1); cyc();
        drv(0, 0, 0, 0, 0); cyc();
        check("fwd_acc", cOut, 1);

        // lastIn alone is ignored
        drv(4, 4, 1, 0, 1); cyc();
        drv(2, 5, 1, 1, 1); cyc();
        drv(0, 0, 0, 0, 0); cyc();
        check("lone_last", cOut, 10);
        cyc();

        // Drain priority under backpressure
        cReadyIn = 0;
        drv(2, 2, 1, 1, 1); cyc();
        drv(0, 0, 0, 0, 0); cyc();
        drv(3, 3, 1, 1, 1); cyc();
        drv(0, 0, 0, 0, 0);
        cValidIn = 1; cIn = 100; cSatIn = 1;
        #1 check("drn_rdy0", cReadyOut, 0);
        cyc();
        check("drn_hold", cOut, 4);
        check("drn_holdv", cValidOut, 1);
        cReadyIn = 1;
        #1 check("drn_rdy_pend", cReadyOut, 0);
        cyc();
        check("drn_local", cOut, 9);
        cyc();
        check("drn_up", cOut, 100);
        check("drn_upsat", cSatOut, 1);
        cValidIn = 0; cSatIn = 0; cyc();
        check("drn_empty", cValidOut, 0);

        // Overflow: new last MACs while pending and blocked
        cReadyIn = 0;
        drv(1, 1, 1, 1, 1); cyc();
        drv(0, 0, 0, 0, 0); cyc();
        drv(2, 2, 1, 1, 1); cyc();
        check("ovf_err0", errOut, 0);
        drv(5, 5, 1, 1, 1); cyc();
        check("ovf_err1", errOut, 1);
        drv(6, 6, 1, 1, 1); cyc();
        drv(0, 0, 0, 0, 0);
        cReadyIn = 1; cyc();
        check("ovf_keep", cOut, 4);
        cyc();
        check("ovf_drop", cValidOut, 0);
        check("ovf_sticky", errOut, 1);

        // Same-edge drain and reload
        drv(1, 1, 1, 1, 1); cyc();
        drv(2, 3, 1, 1, 1); cyc();
        check("b2b_old", cOut, 1);
        drv(0, 0, 0, 0, 0); cyc();
        check("b2b_new", cOut, 6);
        cyc();

        // Async reset mid-accumulation with a blocked result
        cReadyIn = 0;
        drv(4, 4, 1, 1, 1); cyc();
        drv(4, 4, 1, 1, 0); cyc();
        #3 resetN = 1'b0;
        #1;
        check("ar_cValid", cValidOut, 0);
        check("ar_aValid", aValidOut, 0);
        check("ar_aOut", aOut, 0);
        check("ar_err", errOut, 0);
        drv(0, 0, 0, 0, 0);
        cReadyIn = 1;
        cyc();
        resetN = 1'b1;
        drv(2, 3, 1, 1, 1); cyc();
        drv(0, 0, 0, 0, 0); cyc();
        check("ar_post", cOut, 6);
        check("ar_postv", cValidOut, 1);

        // ACC=16: three (127,127) MACs
        sA = 127; sB = 127; sV = 1; sL = 0; cyc(); cyc();
        sL = 1; cyc();
        sV = 0; sL = 0; cyc();
        check("sat1_val", s1c, 32767);
        check("sat1_flag", s1cs, 1);
        check("sat0_val", s0c, -17149);
        check("sat0_flag", s0cs, 1);
        check("sat_err", s1err | s0err, 0);
        sA = 1; sB = 1; sV = 1; sL = 1; cyc();
        sV = 0; sL = 0; cyc();
        check("sat1_clr", s1cs, 0);
        check("sat0_clr", s0cs, 0);
        check("sat0_next", s0c, 1);

        // A few mixed vectors under model compare only
        drv(-128, -128, 1, 1, 0); cyc();
        drv(127, -128, 1, 1, 0);  cyc();
        drv(-1, 1, 1, 1, 1);      cyc();
        drv(0, 0, 0, 0, 0);
        repeat (3) cyc();

        chk_on = 0;
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/integer_systolic_pe.md
INTEGER_SYSTOLIC_PE -- requirements
Module: integer_systolic_pe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, signed operand width.
REQ-002 SHALL have parameter ACC, default 32, signed accumulator/result width, ACC >= 2*WIDTH.
REQ-003 SHALL have parameter SATURATE, default 1: 1 = clamp accumulation, 0 = two's-complement wrap.
REQ-004 SHALL use one clock and an asynchronous, active-low reset; ports named clock and resetN.
REQ-005 Ports, in order:
 clock  in  1  sole clock, rising edge
 resetN  in  1  async reset, active low
 aIn  in  WIDTH  signed A operand
 aValidIn  in  1  A valid
 lastIn  in  1  marks final product of a dot product; travels with A
 bIn  in  WIDTH  signed B operand
 bValidIn  in  1  B valid
 aOut / aValidOut / lastOut  out  WIDTH/1/1  registered A forward to east neighbour
 bOut / bValidOut  out  WIDTH/1  registered B forward to south neighbour
 cIn / cSatIn / cValidIn  in  ACC/1/1  drain chain from upstream PE
 cReadyOut  out  1  this PE accepts cIn
 cOut / cSatOut / cValidOut  out  ACC/1/1  drain chain result to downstream
 cReadyIn  in  1  downstream accepts cOut
 errOut  out  1  sticky result-overflow flag

Function
REQ-006 SHALL register aIn, aValidIn, lastIn, bIn, bValidIn to their outputs every cycle, 1-cycle latency, no backpressure.
REQ-007 A MAC SHALL fire on an edge where aValidIn && bValidIn; otherwise accumulator holds.
REQ-008 Product SHALL be full-precision signed 2*WIDTH bits, sign-extended to ACC+1 before the add.
REQ-009 SATURATE=1: sum > 2^(ACC-1)-1 SHALL clamp to 2^(ACC-1)-1, sum < -2^(ACC-1) SHALL clamp to -2^(ACC-1), and a per-dot-product sticky sat bit SHALL set.
REQ-010 SATURATE=0: sum SHALL wrap modulo 2^ACC; sat bit SHALL be set on any overflow (flag only).
REQ-011 On a MAC with lastIn=1, final sum and sat bit SHALL load the local result register, set pending, and clear accumulator and sat bit to 0 on the same edge (no bubble between dot products).
REQ-012 lastIn with no MAC firing SHALL be ignored.
REQ-013 Output slot free = !cValidOut || cReadyIn; on a free-slot edge cOut SHALL load local result if pending (clearing pending), else cIn/cSatIn if cValidIn, else cValidOut <= 0.
REQ-014 Local result SHALL have priority over upstream; cReadyOut = slot free && !pending, combinational.
REQ-015 Pending cleared and new last MAC on the same edge SHALL both succeed: old result to cOut, new result pending.
REQ-016 New last MAC while pending and slot not free SHALL drop the new result, keep the old, and set errOut sticky until reset.
REQ-017 Latency: last MAC sampled at edge k -> cValidOut=1 after edge k+1 when slot free at k+1.
REQ-018 cOut/cSatOut SHALL hold stable while cValidOut && !cReadyIn.

Reset
REQ-019 resetN low SHALL immediately clear all registered outputs, accumulator, sat bit, pending, local result and errOut to 0, mid-operation included.
REQ-020 First MAC after resetN deasserts SHALL start from accumulator 0.

Verification
REQ-021 Dot product: (3,-4),(5,2,last), cReadyIn=1 -> cOut=-2, cSatOut=0, cValidOut one cycle after last MAC edge; next dot product starts at 0.
REQ-022 Saturation ACC=16: three (127,127) MACs, last on third -> SATURATE=1: cOut=32767, cSatOut=1; SATURATE=0: cOut=-17149, cSatOut=1.
REQ-023 Forwarding: aIn=-7 aValidIn=1, bValidIn=0 -> aOut=-7, aValidOut=1 next cycle, accumulator unchanged.
REQ-024 Drain: cReadyIn=0, cValidOut=1, pending=1, cValidIn=1 -> cReadyOut=0, cOut held; cReadyIn=1 -> local result out first, then upstream value.
REQ-025 Overflow: cReadyIn=0, two last MACs while pending -> errOut=1, first result retained, second dropped.
REQ-026 Reset mid-accumulation: resetN low between MACs -> all outputs 0 asynchronously; post-reset (2,3,last) -> cOut=6.
